// File: rtl/pkt_fifo_pkg.sv
// pkt_fifo_pkg: default parameters and stored-entry layout for pkt_fifo
package pkt_fifo_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AE_THRESH = 2;
    typedef struct packed {
        logic                 last;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/pkt_fifo.sv
// pkt_fifo: packet FIFO that exposes beats to the reader only once their packet's last beat is written
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_last,
    input  logic                     wr_drop,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     err_oversize,
    input  logic                     err_clr
);
    localparam int PW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } ent_t;
    logic [PW-1:0] wptr, cptr, rptr, committed;
    logic wr_en, rd_en, commit, pop_last;
    ent_t wdata, rdata;
    assign count        = wptr - rptr;
    assign committed    = cptr - rptr;
    assign wr_ready     = count < PW'(DEPTH);
    assign rd_valid     = rptr != cptr;
    assign wr_en        = wr_valid && wr_ready && !wr_drop;
    assign rd_en        = rd_valid && rd_ready;
    assign commit       = wr_en && wr_last;
    assign pop_last     = rd_en && rdata.last;
    assign wdata        = '{last: wr_last, data: wr_data};
    assign rd_data      = rdata.data;
    assign rd_last      = rdata.last;
    assign almost_full  = count >= PW'(AF_THRESH);
    assign almost_empty = committed <= PW'(AE_THRESH);
    fifo_ram #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wptr[PW-2:0]),
        .wdata(wdata),
        .raddr(rptr[PW-2:0]),
        .rdata(rdata)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            cptr         <= '0;
            rptr         <= '0;
            pkt_count    <= '0;
            err_oversize <= 1'b0;
        end else begin
            if (wr_drop) wptr <= cptr;
            else if (wr_en) wptr <= wptr + 1'b1;
            if (commit) cptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            pkt_count <= pkt_count + PW'(commit) - PW'(pop_last);
            // a single packet filling the whole FIFO can never commit
            if (count == PW'(DEPTH) && cptr == rptr) err_oversize <= 1'b1;
            else if (err_clr) err_oversize <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: randomized scoreboard bench for pkt_fifo against a queue-based packet model
module tb_pkt_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AF = DEPTH - 2;
    localparam int AE = 2;
    localparam int PW = $clog2(DEPTH) + 1;

    logic clk = 0, rst = 0;
    logic wr_valid = 0, wr_last = 0, wr_drop = 0, rd_ready = 0, err_clr = 0;
    logic [WIDTH-1:0] wr_data = '0;
    logic wr_ready, rd_valid, rd_last, almost_full, almost_empty, err_oversize;
    logic [WIDTH-1:0] rd_data;
    logic [PW-1:0] count, pkt_count;

    pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_last(wr_last), .wr_drop(wr_drop),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .count(count), .pkt_count(pkt_count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .err_oversize(err_oversize), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed beats awaiting read, and the open packet being built
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] part_q[$];
    logic [WIDTH:0] popped;
    int  npkts = 0, mcount = 0;
    bit  merr = 0, wr_ok, rd_ok;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            part_q.delete();
            npkts = 0;
            mcount = 0;
            merr = 0;
        end else begin
            wr_ok = mcount < DEPTH;
            rd_ok = exp_q.size() > 0 && rd_ready;
            if (mcount == DEPTH && exp_q.size() == 0) merr = 1;
            else if (err_clr) merr = 0;
            if (rd_ok) begin
                popped = exp_q.pop_front();
                if (popped[WIDTH]) npkts--;
            end
            if (wr_drop) part_q.delete();
            else if (wr_valid && wr_ok) begin
                part_q.push_back({wr_last, wr_data});
                if (wr_last) begin
                    exp_q = {exp_q, part_q};
                    part_q.delete();
                    npkts++;
                end
            end
            mcount = exp_q.size() + part_q.size();
        end
    end

    // Monitor: compare every presented output against the model, away from the clock edge
    always @(negedge clk) begin
        if (rst) begin
            chk("wr_ready", wr_ready, mcount < DEPTH);
            chk("rd_valid", rd_valid, exp_q.size() != 0);
            chk("count", count, mcount);
            chk("pkt_count", pkt_count, npkts);
            chk("almost_full", almost_full, mcount >= AF);
            chk("almost_empty", almost_empty, exp_q.size() <= AE);
            chk("err_oversize", err_oversize, merr);
            if (rd_valid && exp_q.size() != 0) begin
                chk("rd_data", rd_data, exp_q[0][WIDTH-1:0]);
                chk("rd_last", rd_last, exp_q[0][WIDTH]);
            end
        end
    end

    task automatic cyc(input logic v, input logic l, input logic d, input logic rr,
                       input logic clr, input logic [WIDTH-1:0] data);
        wr_valid = v; wr_last = l; wr_drop = d; rd_ready = rr; err_clr = clr; wr_data = data;
        @(posedge clk);
        #1;
        wr_valid = 0; wr_last = 0; wr_drop = 0; rd_ready = 0; err_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, '0);
    endtask

    initial begin
        #12;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        @(posedge clk); #1 rst = 1;
        idle(2);

        // three-beat packet, then read it out
        cyc(1, 0, 0, 0, 0, 32'hA1);
        cyc(1, 0, 0, 0, 0, 32'hA2);
        @(negedge clk) chk("pre_commit_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        cyc(1, 1, 0, 0, 0, 32'hA3);
        @(negedge clk) begin
            chk("post_commit_rd_valid", rd_valid, 1);
            chk("pkt1", pkt_count, 1);
            chk("first_data", rd_data, 32'hA1);
        end
        @(posedge clk); #1;
        drain(3);
        chk("pkt0", pkt_count, 0);

        // partial packet dropped
        cyc(1, 0, 0, 0, 0, 32'hB1);
        cyc(1, 0, 0, 0, 0, 32'hB2);
        cyc(0, 0, 1, 0, 0, '0);
        chk("drop_count", count, 0);
        chk("drop_rd_valid", rd_valid, 0);

        // fill with one-beat packets
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 0, 32'hC0 + i);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_count", count, DEPTH);
        chk("full_af", almost_full, 1);
        cyc(1, 1, 0, 0, 0, 32'hDEAD);
        chk("ignored_count", count, DEPTH);
        cyc(0, 0, 0, 1, 0, '0);
        chk("read_frees_wr_ready", wr_ready, 1);
        drain(DEPTH);

        // oversize packet deadlock
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 0, 32'hE0 + i);
        idle(1);
        chk("oversize_err", err_oversize, 1);
        chk("oversize_rd_valid", rd_valid, 0);
        cyc(0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, '0);
        chk("cleared_err", err_oversize, 0);
        chk("cleared_count", count, 0);

        // commit B while reading last beat of A
        cyc(1, 1, 0, 0, 0, 32'hF1);
        chk("a_pkt", pkt_count, 1);
        cyc(1, 1, 0, 1, 0, 32'hF2);
        chk("same_cycle_pkt", pkt_count, 1);
        drain(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 40) == 0,
                ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom);
        cyc(0, 0, 1, 0, 1, '0);
        drain(2 * DEPTH);

        // asynchronous reset mid-packet
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 32'h50 + i);
        chk("pre_rst_count", count, 5);
        #2 rst = 0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_wr_ready", wr_ready, 1);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_pkt", pkt_count, 0);
        chk("arst_ae", almost_empty, 1);
        chk("arst_af", almost_full, 0);
        chk("arst_err", err_oversize, 0);
        @(posedge clk); #1 rst = 1;
        cyc(1, 1, 0, 0, 0, 32'h77);
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
